// File: rtl/riscp_pkg.sv
// Shared definitions for the core's PC stage: datapath width, reset fetch address and FSM state encoding.
package riscp_pkg;

  localparam int PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } pc_state_t;

endpackage

// File: rtl/pc_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by synchronous rst.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, IDLE/RUN/HALT control FSM and retired-instruction count.
// Define PC_BOUNDS_CHECK_EN to trap advances to next_pc >= IMEM_DEPTH into the FAULT state.
module pc_unit
  import riscp_pkg::*;
#(
  parameter int               WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter int               IMEM_DEPTH = 256,
  parameter int               CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic [WIDTH-1:0]     next_pc,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus1,
  output logic                 fetch_valid,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  pc_state_t state;
  logic      advance;
  logic      inc;

  // halt_req outranks stall, which outranks an advance
  assign advance     = (state == RUN) && !halt_req && !stall;
  assign pc_plus1    = pc + 1'b1;
  assign fetch_valid = (state == RUN) && !stall;
  assign halted      = (state == HALT);

`ifdef PC_BOUNDS_CHECK_EN
  logic out_of_range;

  assign out_of_range = (32'(next_pc) >= 32'(IMEM_DEPTH));
  assign inc          = advance && !out_of_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (halt_req) begin
            state <= HALT;
          end else if (!stall) begin
            if (out_of_range) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end
`else
  // Depth only matters to the bounds check; the name keeps lint quiet about it here.
  logic unused_imem_depth;

  assign unused_imem_depth = (32'(IMEM_DEPTH) == 32'd0);
  assign inc               = advance;
  assign fault             = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (halt_req)    state <= HALT;
          else if (!stall) pc    <= next_pc;
        end
        default: state <= state;
      endcase
    end
  end
`endif

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retired (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .count(retired_cnt)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] next_pc = 16'h0000;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        fetch_valid;
  logic        halted;
  logic        fault;
  logic [3:0]  retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       nm;
    bit          chk;
    logic [15:0] pc;
    logic [15:0] pp1;
    logic [3:0]  cnt;
    logic        fv;
    logic        hlt;
    logic        flt;
  } exp_t;

  exp_t sb[$];

  pc_unit #(
    .WIDTH     (16),
    .RESET_PC  (16'h0000),
    .IMEM_DEPTH(256),
    .CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .halt_req   (halt_req),
    .next_pc    (next_pc),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .fetch_valid(fetch_valid),
    .halted     (halted),
    .fault      (fault),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs of the current cycle are stable at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk) begin
        cmp(e.nm, "pc",          pc,                  e.pc);
        cmp(e.nm, "pc_plus1",    pc_plus1,            e.pp1);
        cmp(e.nm, "retired_cnt", {12'h0, retired_cnt}, {12'h0, e.cnt});
        cmp(e.nm, "fetch_valid", {15'h0, fetch_valid}, {15'h0, e.fv});
        cmp(e.nm, "halted",      {15'h0, halted},      {15'h0, e.hlt});
        cmp(e.nm, "fault",       {15'h0, fault},       {15'h0, e.flt});
      end
    end
  end

  // One clock cycle: apply inputs just after the rising edge and queue the outputs expected in that cycle.
  task automatic cyc(input string nm, input bit r, input bit s, input bit st, input bit h,
                     input logic [15:0] np, input bit chk, input logic [15:0] epc,
                     input logic [3:0] ecnt, input bit efv, input bit ehlt, input bit eflt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; start = s; stall = st; halt_req = h; next_pc = np;
    e.nm = nm; e.chk = chk; e.pc = epc; e.pp1 = epc + 16'd1; e.cnt = ecnt;
    e.fv = efv; e.hlt = ehlt; e.flt = eflt;
    sb.push_back(e);
  endtask

  initial begin
    int guard;
    cyc("rst0",    1, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0);
    cyc("reset",   1, 0, 0, 0, 16'h0000, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("idle",    0, 0, 1, 1, 16'h0077, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("start",   0, 1, 0, 0, 16'h0077, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("run0",    0, 0, 0, 0, 16'h0001, 1, 16'h0000, 4'd0, 1, 0, 0);
    cyc("run1",    0, 0, 0, 0, 16'h0002, 1, 16'h0001, 4'd1, 1, 0, 0);
    cyc("run2",    0, 0, 0, 0, 16'h0003, 1, 16'h0002, 4'd2, 1, 0, 0);
    cyc("run3",    0, 0, 0, 0, 16'h0004, 1, 16'h0003, 4'd3, 1, 0, 0);
    cyc("run4",    0, 0, 0, 0, 16'h0005, 1, 16'h0004, 4'd4, 1, 0, 0);
    cyc("stall1",  0, 0, 1, 0, 16'h0040, 1, 16'h0005, 4'd5, 0, 0, 0);
    cyc("stall2",  0, 0, 1, 0, 16'h0040, 1, 16'h0005, 4'd5, 0, 0, 0);
    cyc("unstall", 0, 0, 0, 0, 16'h0040, 1, 16'h0005, 4'd5, 1, 0, 0);
    cyc("haltreq", 0, 0, 1, 1, 16'h1234, 1, 16'h0040, 4'd6, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("halted", 0, i[0], i[0], ~i[0], 16'(i * 7 + 1), 1, 16'h0040, 4'd6, 0, 1, 0);
    end
    cyc("rst_halt", 1, 0, 0, 0, 16'h0000, 1, 16'h0040, 4'd6, 0, 1, 0);
    cyc("idle2",    0, 0, 0, 0, 16'h0033, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("start2",   0, 1, 0, 0, 16'h0033, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("run_33",   0, 0, 0, 0, 16'h0033, 1, 16'h0000, 4'd0, 1, 0, 0);
    cyc("rst_run",  1, 0, 0, 0, 16'h0099, 1, 16'h0033, 4'd1, 1, 0, 0);
    cyc("post_rst", 0, 0, 0, 0, 16'h0055, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("hold_rst", 0, 0, 0, 0, 16'h0055, 1, 16'h0000, 4'd0, 0, 0, 0);
    cyc("start3",   0, 1, 0, 0, 16'h0055, 1, 16'h0000, 4'd0, 0, 0, 0);
`ifdef PC_BOUNDS_CHECK_EN
    cyc("to_ff",     0, 0, 0, 0, 16'h00FF, 1, 16'h0000, 4'd0, 1, 0, 0);
    cyc("oob_stall", 0, 0, 1, 0, 16'h0100, 1, 16'h00FF, 4'd1, 0, 0, 0);
    cyc("oob_adv",   0, 0, 0, 0, 16'h0100, 1, 16'h00FF, 4'd1, 1, 0, 0);
    cyc("fault1",    0, 1, 0, 0, 16'h0010, 1, 16'h00FF, 4'd1, 0, 0, 1);
    cyc("fault2",    0, 0, 0, 1, 16'h0010, 1, 16'h00FF, 4'd1, 0, 0, 1);
`else
    cyc("to_ffff",   0, 0, 0, 0, 16'hFFFF, 1, 16'h0000, 4'd0, 1, 0, 0);
    cyc("wrap",      0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 4'd1, 1, 0, 0);
    cyc("wrapped",   0, 0, 0, 0, 16'h0001, 1, 16'h0000, 4'd2, 1, 0, 0);
    for (int k = 0; k < 18; k++) begin
      cyc("sat", 0, 0, 0, 0, 16'(k + 2), 1, 16'(k + 1), (k + 3 > 15) ? 4'hF : 4'(k + 3), 1, 0, 0);
    end
    cyc("sat_end",   0, 0, 1, 0, 16'h0014, 1, 16'h0013, 4'hF, 0, 0, 0);
`endif
    cyc("tail",      0, 0, 1, 0, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
